// File: rtl/algo_1r2m_pkg.sv
// Shared definitions for the 1R2M algorithmic memory and its front-end schedulers.
package algo_1r2m_pkg;
  localparam int NUMWRPT     = 2;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_BITADDR = 13;

  typedef enum logic {INIT, RUN} state_t;

  typedef logic [DEF_BITADDR-1:0] adr_t;
  typedef logic [DEF_WIDTH-1:0]   din_t;
endpackage

// File: rtl/algo_1r2m_wr_sched_if.sv
// Requester and memory write-port bundle for algo_1r2m_wr_sched.
// master = scheduler side, slave = requesters plus memory.
interface algo_1r2m_wr_sched_if #(
  parameter int NUMREQ  = 4,
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13
);
  import algo_1r2m_pkg::*;

  logic                         ready;
  logic [NUMWRPT-1:0]           ma_bp;
  logic [NUMREQ-1:0]            req;
  logic [NUMREQ*BITADDR-1:0]    req_adr;
  logic [NUMREQ*WIDTH-1:0]      req_din;
  logic [NUMREQ-1:0]            gnt;
  logic [NUMWRPT-1:0]           ma_write;
  logic [NUMWRPT*BITADDR-1:0]   ma_adr;
  logic [NUMWRPT*WIDTH-1:0]     ma_din;

  modport master (
    input  ready, ma_bp, req, req_adr, req_din,
    output gnt, ma_write, ma_adr, ma_din
  );

  modport slave (
    output ready, ma_bp, req, req_adr, req_din,
    input  gnt, ma_write, ma_adr, ma_din
  );
endinterface

// File: rtl/algo_rr_pick2.sv
// Rotating two-winner picker: first two set bits of req searching from ptr upward, wrapping.
// Pure combinational; shared by the multi-port schedulers.
module algo_rr_pick2 #(
  parameter int NUMREQ = 4,
  parameter int BITREQ = 2
) (
  input  logic [NUMREQ-1:0] req,
  input  logic [BITREQ-1:0] ptr,
  output logic [BITREQ-1:0] idx0,
  output logic              vld0,
  output logic [BITREQ-1:0] idx1,
  output logic              vld1
);
  always_comb begin
    idx0 = '0;
    vld0 = 1'b0;
    idx1 = '0;
    vld1 = 1'b0;
    for (int k = 0; k < NUMREQ; k++) begin
      if (req[(int'(ptr) + k) % NUMREQ]) begin
        if (!vld0) begin
          vld0 = 1'b1;
          idx0 = BITREQ'((int'(ptr) + k) % NUMREQ);
        end else if (!vld1) begin
          vld1 = 1'b1;
          idx1 = BITREQ'((int'(ptr) + k) % NUMREQ);
        end
      end
    end
  end
endmodule

// File: rtl/algo_1r2m_wr_sched.sv
// Write-request scheduler: up to two requesters per cycle onto the 1R2M write ports via a
// registered stage. Round-robin when ALGO_1R2M_WRSCHED_RR_EN is defined, else fixed priority.
module algo_1r2m_wr_sched
  import algo_1r2m_pkg::*;
#(
  parameter int NUMREQ  = 4,
  parameter int BITREQ  = 2,
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  algo_1r2m_wr_sched_if.master  bus
);
  state_t                     state, state_nxt;
  logic [BITREQ-1:0]          rr_ptr;
  logic [BITREQ-1:0]          idx0, idx1;
  logic                       vld0, vld1, pair_ok, go;
  logic [BITADDR-1:0]         adr0, adr1;
  logic [WIDTH-1:0]           din0, din1;
  logic [NUMREQ-1:0]          gnt;
  logic [NUMWRPT-1:0]         ma_write;
  logic [NUMWRPT*BITADDR-1:0] ma_adr;
  logic [NUMWRPT*WIDTH-1:0]   ma_din;

  algo_rr_pick2 #(.NUMREQ(NUMREQ), .BITREQ(BITREQ)) u_pick (
    .req  (bus.req),
    .ptr  (rr_ptr),
    .idx0 (idx0),
    .vld0 (vld0),
    .idx1 (idx1),
    .vld1 (vld1)
  );

  assign adr0 = bus.req_adr[int'(idx0)*BITADDR +: BITADDR];
  assign adr1 = bus.req_adr[int'(idx1)*BITADDR +: BITADDR];
  assign din0 = bus.req_din[int'(idx0)*WIDTH +: WIDTH];
  assign din1 = bus.req_din[int'(idx1)*WIDTH +: WIDTH];

  // A same-address second pick leaves port 1 idle rather than searching further.
  assign pair_ok = vld1 & (adr1 != adr0);

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    gnt       = '0;
    case (state)
      INIT: if (bus.ready) state_nxt = RUN;
      RUN: begin
        if (!bus.ready) state_nxt = INIT;
        go = bus.ready & ~(bus.ma_bp[0] & |ma_write);
      end
      default: state_nxt = INIT;
    endcase
    if (go && vld0)    gnt[idx0] = 1'b1;
    if (go && pair_ok) gnt[idx1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      ma_write <= '0;
      ma_adr   <= '0;
      ma_din   <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        ma_write <= {pair_ok, vld0};
        if (vld0) begin
          ma_adr[0 +: BITADDR] <= adr0;
          ma_din[0 +: WIDTH]   <= din0;
        end
        if (pair_ok) begin
          ma_adr[BITADDR +: BITADDR] <= adr1;
          ma_din[WIDTH +: WIDTH]     <= din1;
        end
      end
    end
  end

`ifdef ALGO_1R2M_WRSCHED_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (go && vld0)
      rr_ptr <= BITREQ'((int'(pair_ok ? idx1 : idx0) + 1) % NUMREQ);
  end
`else
  assign rr_ptr = '0;
`endif

  assign bus.gnt      = gnt;
  assign bus.ma_write = ma_write;
  assign bus.ma_adr   = ma_adr;
  assign bus.ma_din   = ma_din;
endmodule

// File: tb/tb_algo_1r2m_wr_sched.sv
// Directed bench for algo_1r2m_wr_sched; expectations follow the build (RR if macro defined).
module tb_algo_1r2m_wr_sched;
  import algo_1r2m_pkg::*;

  localparam int NUMREQ = 4, BITREQ = 2, WIDTH = 32, BITADDR = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  algo_1r2m_wr_sched_if #(.NUMREQ(NUMREQ), .WIDTH(WIDTH), .BITADDR(BITADDR)) bus ();

  algo_1r2m_wr_sched #(.NUMREQ(NUMREQ), .BITREQ(BITREQ), .WIDTH(WIDTH), .BITADDR(BITADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_adr();
    for (int i = 0; i < NUMREQ; i++) begin
      bus.req_adr[i*BITADDR +: BITADDR] = BITADDR'(13'h100 + i);
      bus.req_din[i*WIDTH +: WIDTH]     = 32'hD000_0000 + i;
    end
  endtask

  localparam logic [25:0] A01 = {13'h101, 13'h100};
  localparam logic [25:0] A23 = {13'h103, 13'h102};
  localparam logic [63:0] D01 = {32'hD000_0001, 32'hD000_0000};

  logic [3:0]  eg[4];
  logic [25:0] ea[4];
  logic [25:0] a_rr_alt;
  logic [3:0]  g_rr_alt;

  initial begin
`ifdef ALGO_1R2M_WRSCHED_RR_EN
    eg = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    ea = '{A01, A23, A01, A23};
    a_rr_alt = A23;
    g_rr_alt = 4'b1100;
`else
    eg = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
    ea = '{A01, A01, A01, A01};
    a_rr_alt = A01;
    g_rr_alt = 4'b0011;
`endif
    bus.ready = 1'b0;
    bus.ma_bp = '0;
    bus.req   = 4'b1111;
    set_adr();
    #3;
    chk("rst_gnt", 64'(bus.gnt), 64'h0);
    chk("rst_write", 64'(bus.ma_write), 64'h0);
    chk("rst_adr", 64'(bus.ma_adr), 64'h0);
    chk("rst_din", 64'(bus.ma_din), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("notready_gnt", 64'(bus.gnt), 64'h0);
    chk("notready_write", 64'(bus.ma_write), 64'h0);

    // ready rises: grants start once the FSM reaches RUN
    bus.ready = 1'b1;
    #1 chk("init_gnt", 64'(bus.gnt), 64'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) chk("stream_write0", 64'(bus.ma_write), 64'h0);
      else begin
        chk("stream_write", 64'(bus.ma_write), 64'h3);
        chk("stream_adr", 64'(bus.ma_adr), 64'(ea[k-1]));
      end
      chk("stream_gnt", 64'(bus.gnt), 64'(eg[k]));
    end
    tick();
    chk("stream_adr_last", 64'(bus.ma_adr), 64'(ea[3]));
    chk("stream_din_first", 64'(bus.ma_din[31:0]), (ea[3] == A01) ? 64'hD000_0000 : 64'hD000_0002);

    // same-address pair: only the first pick goes out
    bus.req = 4'b0101;
    bus.req_adr[0 +: 13]  = 13'h0A5;
    bus.req_adr[26 +: 13] = 13'h0A5;
    #1 chk("same_gnt", 64'(bus.gnt), 64'h1);
    tick();
    chk("same_write", 64'(bus.ma_write), 64'h1);
    chk("same_adr0", 64'(bus.ma_adr[12:0]), 64'h0A5);
    chk("same_din0", 64'(bus.ma_din[31:0]), 64'hD000_0000);
    bus.req = 4'b0100;
    #1 chk("same_gnt2", 64'(bus.gnt), 64'h4);
    tick();
    chk("same_write2", 64'(bus.ma_write), 64'h1);
    chk("same_din2", 64'(bus.ma_din[31:0]), 64'hD000_0002);

    // back-pressure with a full stage holds it
    set_adr();
    bus.req = 4'b0011;
    #1 chk("bp_pre_gnt", 64'(bus.gnt), 64'h3);
    tick();
    chk("bp_pre_adr", 64'(bus.ma_adr), 64'(A01));
    bus.ma_bp = 2'b11;
    bus.req   = 4'b1100;
    #1 chk("bp_gnt", 64'(bus.gnt), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_write", 64'(bus.ma_write), 64'h3);
      chk("bp_hold_adr", 64'(bus.ma_adr), 64'(A01));
      chk("bp_hold_din", bus.ma_din, D01);
      chk("bp_hold_gnt", 64'(bus.gnt), 64'h0);
    end
    bus.ma_bp = 2'b00;
    #1 chk("bp_release_gnt", 64'(bus.gnt), 64'hC);
    tick();
    chk("bp_release_adr", 64'(bus.ma_adr), 64'(A23));
    bus.req = 4'b0000;
    #1 chk("idle_gnt", 64'(bus.gnt), 64'h0);
    tick();
    chk("drain_write", 64'(bus.ma_write), 64'h0);

    // back-pressure with an empty stage is not a stall
    bus.ma_bp = 2'b11;
    bus.req   = 4'b0001;
    #1 chk("bp_empty_gnt", 64'(bus.gnt), 64'h1);
    tick();
    chk("bp_empty_write", 64'(bus.ma_write), 64'h1);
    chk("bp_empty_adr", 64'(bus.ma_adr[12:0]), 64'h100);
    bus.req = 4'b0010;
    #1 chk("bp_one_gnt", 64'(bus.gnt), 64'h0);
    bus.ma_bp = 2'b00;
    #1 chk("bp_one_release", 64'(bus.gnt), 64'h2);
    tick();
    chk("single_adr", 64'(bus.ma_adr[12:0]), 64'h101);

    // ready drop: back to INIT with the stage held
    bus.ready = 1'b0;
    bus.req   = 4'b1111;
    #1 chk("rdy_drop_gnt", 64'(bus.gnt), 64'h0);
    tick();
    chk("rdy_hold_write", 64'(bus.ma_write), 64'h1);
    chk("rdy_hold_adr", 64'(bus.ma_adr[12:0]), 64'h101);
    bus.ready = 1'b1;
    #1 chk("rdy_init_gnt", 64'(bus.gnt), 64'h0);
    tick();
    chk("rdy_run_write", 64'(bus.ma_write), 64'h1);
    chk("rdy_run_gnt", 64'(bus.gnt), 64'(g_rr_alt));
    tick();
    chk("rdy_run_adr", 64'(bus.ma_adr), 64'(a_rr_alt));
    chk("rdy_run_gnt2", 64'(bus.gnt), 64'h3);
    tick();
    chk("pre_rst_write", 64'(bus.ma_write), 64'h3);

    // asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    chk("mid_rst_write", 64'(bus.ma_write), 64'h0);
    chk("mid_rst_adr", 64'(bus.ma_adr), 64'h0);
    chk("mid_rst_gnt", 64'(bus.gnt), 64'h0);
    rst = 1'b0;
    #1 chk("post_rst_init_gnt", 64'(bus.gnt), 64'h0);
    tick();
    chk("post_rst_write", 64'(bus.ma_write), 64'h0);
    chk("post_rst_gnt", 64'(bus.gnt), 64'h3);
    tick();
    chk("post_rst_adr", 64'(bus.ma_adr), 64'(A01));
    chk("post_rst_write2", 64'(bus.ma_write), 64'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
